// File: rtl/cmd_engine.sv
// Byte-stream command processor for the pin mux: checksummed shadow writes,
// status-coded responses, inter-byte timeout and synchronised input readback.
module cmd_engine #(
    parameter int OUTPUT_COUNT   = 16,
    parameter int INPUT_COUNT    = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int SEL_W = $clog2(INPUT_COUNT) * OUTPUT_COUNT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [INPUT_COUNT-1:0]  in_pins,
    output logic [SEL_W-1:0]        selectors,
    output logic [OUTPUT_COUNT-1:0] enabled_out,
    output logic                    busy,
    output logic                    rx_overrun
);
    localparam int MAP_B = (SEL_W + 7) / 8;
    localparam int EN_B  = (OUTPUT_COUNT + 7) / 8;
    localparam int IN_B  = (INPUT_COUNT + 7) / 8;
    localparam int MX_B  = (MAP_B > EN_B) ? MAP_B : EN_B;
    localparam int PAY_B = (MX_B > IN_B) ? MX_B : IN_B;
    localparam int PAY_W = PAY_B * 8;
    localparam int CNT_W = $clog2(PAY_B) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_OP  = 8'h01;
    localparam logic [7:0] ST_BAD_CS  = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;

    typedef enum logic [2:0] {
        IDLE, RX_PAYLOAD, RX_CSUM, COMMIT, TX_STATUS, TX_DATA, TX_CSUM
    } state_t;

    state_t                 state, state_nx;
    logic [PAY_W-1:0]       shadow, pay;
    logic [CNT_W-1:0]       cnt, len;
    logic [TMO_W-1:0]       tmo;
    logic [7:0]             status, rcsum, tcsum;
    logic                   is_map;
    logic [INPUT_COUNT-1:0] pin_s1, pin_s2;
    logic                   expired, last;

    assign expired = (tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign last    = (cnt == len - CNT_W'(1));
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            IDLE: if (rx_valid && rx_data != 8'h00)
                state_nx = (rx_data == 8'h03 || rx_data == 8'h04) ? RX_PAYLOAD : TX_STATUS;
            RX_PAYLOAD: begin
                if (rx_valid) begin
                    if (last) state_nx = RX_CSUM;
                end else if (expired) state_nx = TX_STATUS;
            end
            RX_CSUM: begin
                if (rx_valid)     state_nx = (rx_data == rcsum) ? COMMIT : TX_STATUS;
                else if (expired) state_nx = TX_STATUS;
            end
            COMMIT: state_nx = TX_STATUS;
            TX_STATUS: begin
                tx_valid = 1'b1;
                tx_data  = status;
                if (tx_ready) state_nx = (status == ST_OK) ? TX_DATA : TX_CSUM;
            end
            TX_DATA: begin
                tx_valid = 1'b1;
                tx_data  = pay[7:0];
                if (tx_ready && last) state_nx = TX_CSUM;
            end
            TX_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = tcsum;
                if (tx_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shadow      <= '0;
            pay         <= '0;
            cnt         <= '0;
            len         <= '0;
            tmo         <= '0;
            status      <= ST_OK;
            rcsum       <= 8'h00;
            tcsum       <= 8'h00;
            is_map      <= 1'b0;
            pin_s1      <= '0;
            pin_s2      <= '0;
            selectors   <= '0;
            enabled_out <= '0;
            rx_overrun  <= 1'b0;
        end else begin
            state      <= state_nx;
            pin_s1     <= in_pins;
            pin_s2     <= pin_s1;
            rx_overrun <= rx_valid && (state == COMMIT || state == TX_STATUS ||
                                       state == TX_DATA || state == TX_CSUM);
            case (state)
                IDLE: if (rx_valid) begin
                    status <= ST_OK;
                    rcsum  <= rx_data;
                    cnt    <= '0;
                    tmo    <= '0;
                    shadow <= '0;
                    is_map <= (rx_data == 8'h04);
                    case (rx_data)
                        8'h00: ;
                        8'h01: begin pay <= PAY_W'(enabled_out); len <= CNT_W'(EN_B); end
                        8'h02: begin pay <= PAY_W'(selectors);   len <= CNT_W'(MAP_B); end
                        8'h03: len <= CNT_W'(EN_B);
                        8'h04: len <= CNT_W'(MAP_B);
                        8'h05: begin pay <= PAY_W'(pin_s2);      len <= CNT_W'(IN_B); end
                        default: status <= ST_BAD_OP;
                    endcase
                end
                RX_PAYLOAD: begin
                    if (rx_valid) begin
                        for (int k = 0; k < PAY_B; k++)
                            if (cnt == CNT_W'(k)) shadow[8*k +: 8] <= rx_data;
                        rcsum <= rcsum ^ rx_data;
                        cnt   <= cnt + CNT_W'(1);
                        tmo   <= '0;
                    end else if (expired) begin
                        shadow <= '0;
                        status <= ST_TIMEOUT;
                    end else tmo <= tmo + TMO_W'(1);
                end
                RX_CSUM: begin
                    if (rx_valid) begin
                        tmo <= '0;
                        if (rx_data != rcsum) status <= ST_BAD_CS;
                    end else if (expired) begin
                        shadow <= '0;
                        status <= ST_TIMEOUT;
                    end else tmo <= tmo + TMO_W'(1);
                end
                // Live registers change only here; the echo reads back the committed value
                COMMIT: begin
                    if (is_map) begin
                        selectors <= shadow[SEL_W-1:0];
                        pay       <= PAY_W'(shadow[SEL_W-1:0]);
                    end else begin
                        enabled_out <= shadow[OUTPUT_COUNT-1:0];
                        pay         <= PAY_W'(shadow[OUTPUT_COUNT-1:0]);
                    end
                end
                TX_STATUS: if (tx_ready) begin
                    tcsum <= status;
                    cnt   <= '0;
                end
                TX_DATA: if (tx_ready) begin
                    tcsum <= tcsum ^ pay[7:0];
                    pay   <= pay >> 8;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_engine.sv
// Randomised and directed bench for cmd_engine against a frame-level reference model.
module tb_cmd_engine;
    localparam int TMO = 50;
    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic tx_ready = 1'b0;
    logic [3:0] in_pins = 4'h0;
    logic use_b = 1'b0;

    logic a_rxv, b_rxv, a_txv, b_txv, a_busy, b_busy, a_ovr, b_ovr, tv;
    logic [7:0] a_txd, b_txd, td;
    logic [31:0] a_sel;
    logic [15:0] a_en;
    logic [23:0] b_sel;
    logic [11:0] b_en;

    assign a_rxv = rx_valid & ~use_b;
    assign b_rxv = rx_valid & use_b;
    assign tv    = use_b ? b_txv : a_txv;
    assign td    = use_b ? b_txd : a_txd;

    always #5 clk = ~clk;

    cmd_engine #(.OUTPUT_COUNT(16), .INPUT_COUNT(4), .TIMEOUT_CYCLES(TMO)) u_a (
        .clk(clk), .rst_n(rst_n), .rx_valid(a_rxv), .rx_data(rx_data),
        .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(tx_ready), .in_pins(in_pins),
        .selectors(a_sel), .enabled_out(a_en), .busy(a_busy), .rx_overrun(a_ovr));

    cmd_engine #(.OUTPUT_COUNT(12), .INPUT_COUNT(3), .TIMEOUT_CYCLES(TMO)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_valid(b_rxv), .rx_data(rx_data),
        .tx_data(b_txd), .tx_valid(b_txv), .tx_ready(tx_ready), .in_pins(in_pins[2:0]),
        .selectors(b_sel), .enabled_out(b_en), .busy(b_busy), .rx_overrun(b_ovr));

    int checks = 0;
    int failures = 0;
    logic [15:0] en_m = '0;
    logic [31:0] sel_m = '0;

    // Reference: whole request frame in, whole response frame out
    function automatic bq_t model(input bq_t cmd);
        bq_t r;
        logic [31:0] v = '0;
        logic [7:0] x;
        int nb = 0;
        case (cmd[0])
            8'h00: return r;
            8'h01: begin v = 32'(en_m); nb = 2; end
            8'h02: begin v = sel_m; nb = 4; end
            8'h05: begin v = 32'(in_pins); nb = 1; end
            8'h03, 8'h04: begin
                nb = (cmd[0] == 8'h03) ? 2 : 4;
                x = cmd[0];
                for (int i = 1; i <= nb; i++) x ^= cmd[i];
                if (x != cmd[nb+1]) begin r = {8'h02, 8'h02}; return r; end
                for (int i = 0; i < nb; i++) v[8*i +: 8] = cmd[i+1];
                if (cmd[0] == 8'h03) en_m = v[15:0]; else sel_m = v;
            end
            default: begin r = {8'h01, 8'h01}; return r; end
        endcase
        x = 8'h00;
        r.push_back(8'h00);
        for (int i = 0; i < nb; i++) begin r.push_back(v[8*i +: 8]); x ^= v[8*i +: 8]; end
        r.push_back(x);
        return r;
    endfunction

    function automatic logic [63:0] pack(input bq_t q);
        logic [63:0] r = '0;
        r[63:56] = 8'(q.size());
        for (int i = 0; i < q.size() && i < 7; i++) r[8*i +: 8] = q[i];
        return r;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bq_t cmd);
        foreach (cmd[i]) send(cmd[i]);
    endtask

    task automatic collect(input bit rnd, input int wait_cyc, output bq_t q);
        int idle = 0;
        bit done = 1'b0;
        q = {};
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (tv && tx_ready) q.push_back(td);
            idle = tv ? 0 : idle + 1;
            if ((q.size() > 0 && idle >= 2) || (q.size() == 0 && c >= wait_cyc)) done = 1'b1;
        end
        tx_ready = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL collect_bound got=%0d bytes exp=frame end", q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_sel, a_en, a_txv, a_txd, a_busy, a_ovr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {a_sel, a_en, a_txv, a_txd, a_busy, a_ovr});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_enable;
        bq_t cmd = {8'h01};
        bq_t exp, got;
        exp = model(cmd);
        send_frame(cmd);
        collect(1'b0, 10, got);
        checks++;
        if (pack(got) !== pack(exp)) begin
            failures++; $display("FAIL read_enable got=%h exp=%h", pack(got), pack(exp));
        end
        checks++;
        if (a_en !== 16'h0000) begin failures++; $display("FAIL en_after_reset got=%h exp=0000", a_en); end
    endtask

    task automatic test_write_enable;
        bq_t cmd = {8'h03, 8'hA5, 8'h0F, 8'hA9};
        bq_t exp, got;
        exp = model(cmd);
        send(8'h03); send(8'hA5); send(8'h0F); send(8'hA9);
        checks++;
        if (a_en !== 16'h0000) begin failures++; $display("FAIL en_too_early got=%h exp=0000", a_en); end
        @(negedge clk);
        checks++;
        if ({a_en, a_txv} !== {16'h0FA5, 1'b1}) begin
            failures++; $display("FAIL en_commit got=%h/%b exp=0fa5/1", a_en, a_txv);
        end
        collect(1'b0, 10, got);
        checks++;
        if (pack(got) !== pack(exp)) begin
            failures++; $display("FAIL write_enable_rsp got=%h exp=%h", pack(got), pack(exp));
        end
    endtask

    task automatic test_bad_csum;
        bq_t cmd = {8'h03, 8'h11, 8'h22, 8'h00};
        bq_t exp, got;
        exp = model(cmd);
        send_frame(cmd);
        collect(1'b1, 10, got);
        checks++;
        if (pack(got) !== pack(exp)) begin
            failures++; $display("FAIL bad_csum_rsp got=%h exp=%h", pack(got), pack(exp));
        end
        checks++;
        if (a_en !== 16'h0FA5) begin failures++; $display("FAIL bad_csum_en got=%h exp=0fa5", a_en); end
    endtask

    task automatic test_backpressure;
        bq_t cmd = {8'h04, 8'h1B, 8'hE4, 8'h00, 8'hFF, 8'h04};
        bq_t exp, got;
        logic [7:0] held = 8'h00;
        int stall = 0, bad = 0, ovr = 0;
        bit done = 1'b0;
        exp = model(cmd);
        send_frame(cmd);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (a_ovr) ovr++;
            if (got.size() == 2 && stall < 10) begin
                tx_ready = 1'b0;
                if (stall == 0) held = td;
                else if (td !== held || !tv) bad++;
                rx_valid = (stall == 3);
                rx_data  = 8'h55;
                stall++;
            end else begin
                rx_valid = 1'b0;
                tx_ready = 1'b1;
                if (tv) got.push_back(td);
            end
            if (got.size() > 0 && !tv) done = 1'b1;
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if (pack(got) !== pack(exp)) begin
            failures++; $display("FAIL stall_rsp got=%h exp=%h", pack(got), pack(exp));
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", bad); end
        checks++;
        if (ovr != 1) begin failures++; $display("FAIL overrun_pulse got=%0d exp=1", ovr); end
        checks++;
        if (a_sel !== 32'hFF00E41B) begin failures++; $display("FAIL map_commit got=%h exp=ff00e41b", a_sel); end
    endtask

    task automatic test_timeout;
        bq_t exp = {8'h03, 8'h03};
        bq_t got;
        int w = 0;
        send(8'h04); send(8'h12);
        while (!tv && w < 200) begin @(negedge clk); w++; end
        checks++;
        if (w < TMO || w > TMO + 1) begin failures++; $display("FAIL timeout_delay got=%0d exp=%0d", w, TMO); end
        collect(1'b0, 10, got);
        checks++;
        if (pack(got) !== pack(exp)) begin
            failures++; $display("FAIL timeout_rsp got=%h exp=%h", pack(got), pack(exp));
        end
        checks++;
        if (a_sel !== sel_m) begin failures++; $display("FAIL timeout_sel got=%h exp=%h", a_sel, sel_m); end
    endtask

    task automatic test_bad_op;
        bq_t c1 = {8'h07};
        bq_t c0 = {8'h00};
        bq_t exp, got;
        exp = model(c1);
        send_frame(c1);
        collect(1'b0, 10, got);
        checks++;
        if (pack(got) !== pack(exp)) begin failures++; $display("FAIL bad_op got=%h exp=%h", pack(got), pack(exp)); end
        exp = model(c0);
        send_frame(c0);
        collect(1'b0, 10, got);
        checks++;
        if (pack(got) !== pack(exp) || a_busy !== 1'b0) begin
            failures++; $display("FAIL nop got=%h/%b exp=%h/0", pack(got), a_busy, pack(exp));
        end
    endtask

    task automatic test_inputs;
        bq_t cmd = {8'h05};
        bq_t exp, got;
        in_pins = 4'hA;
        repeat (3) @(negedge clk);
        exp = model(cmd);
        send_frame(cmd);
        collect(1'b0, 10, got);
        checks++;
        if (pack(got) !== pack(exp)) begin failures++; $display("FAIL read_inputs got=%h exp=%h", pack(got), pack(exp)); end
    endtask

    task automatic test_reset_mid;
        bq_t cmd = {8'h02};
        bq_t exp, got;
        send(8'h03); send(8'h5A);
        checks++;
        if (a_busy !== 1'b1) begin failures++; $display("FAIL busy_rx got=%b exp=1", a_busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a_sel, a_en, a_txv, a_txd, a_busy, a_ovr} !== '0) begin
            failures++; $display("FAIL reset_mid got=%h exp=0", {a_sel, a_en, a_txv, a_txd, a_busy, a_ovr});
        end
        @(negedge clk) rst_n = 1'b1;
        send(8'h01);
        checks++;
        if (a_txv !== 1'b1) begin failures++; $display("FAIL tx_pending got=%b exp=1", a_txv); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_txv !== 1'b0) begin failures++; $display("FAIL tx_async_drop got=%b exp=0", a_txv); end
        @(negedge clk) rst_n = 1'b1;
        en_m = '0; sel_m = '0;
        exp = model(cmd);
        send_frame(cmd);
        collect(1'b0, 10, got);
        checks++;
        if (pack(got) !== pack(exp)) begin failures++; $display("FAIL read_after_reset got=%h exp=%h", pack(got), pack(exp)); end
    endtask

    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            bq_t cmd, exp, got;
            int k = $urandom_range(0, 7);
            int nb;
            logic [7:0] op, x, b;
            in_pins = 4'($urandom);
            repeat (3) @(negedge clk);
            case (k)
                0: op = 8'h00;
                1: op = 8'h01;
                2: op = 8'h02;
                3: op = 8'h05;
                4, 5: op = 8'h03;
                6: op = 8'h04;
                default: op = 8'($urandom_range(6, 255));
            endcase
            cmd.push_back(op);
            if (op == 8'h03 || op == 8'h04) begin
                nb = (op == 8'h03) ? 2 : 4;
                x = op;
                for (int i = 0; i < nb; i++) begin b = 8'($urandom); cmd.push_back(b); x ^= b; end
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                cmd.push_back(x);
            end
            exp = model(cmd);
            send_frame(cmd);
            collect(1'b1, 10, got);
            checks++;
            if (pack(got) !== pack(exp)) begin
                failures++; $display("FAIL random_rsp[%0d] op=%h got=%h exp=%h", it, op, pack(got), pack(exp));
            end
            checks++;
            if ({a_sel, a_en} !== {sel_m, en_m}) begin
                failures++; $display("FAIL random_live[%0d] got=%h exp=%h", it, {a_sel, a_en}, {sel_m, en_m});
            end
        end
    endtask

    task automatic test_narrow;
        bq_t exp = {8'h00, 8'hFF, 8'h0F, 8'hF0};
        bq_t got;
        use_b = 1'b1;
        send(8'h03); send(8'hFF); send(8'hFF); send(8'h03);
        collect(1'b0, 10, got);
        checks++;
        if (pack(got) !== pack(exp)) begin failures++; $display("FAIL narrow_echo got=%h exp=%h", pack(got), pack(exp)); end
        checks++;
        if (b_en !== 12'hFFF) begin failures++; $display("FAIL narrow_en got=%h exp=fff", b_en); end
        send(8'h01);
        collect(1'b0, 10, got);
        checks++;
        if (pack(got) !== pack(exp)) begin failures++; $display("FAIL narrow_read got=%h exp=%h", pack(got), pack(exp)); end
        use_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_enable();
        test_write_enable();
        test_bad_csum();
        test_backpressure();
        test_timeout();
        test_bad_op();
        test_inputs();
        test_reset_mid();
        test_random();
        test_narrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
